// File: rtl/hier_dispatch_pkg.sv
// Shared types and defaults for the hierarchical fan-out dispatcher.
package hier_dispatch_pkg;

    localparam int NUM_CHILDREN_DEF = 10;
    localparam int CREDITS_DEF      = 4;
    localparam int CREDIT_W         = 4;

    typedef logic [CREDIT_W-1:0] credit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        SEND   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_credit_arbiter.sv
// Combinational round-robin search: first child after last_grant (wrapping) that holds credit.
module rr_credit_arbiter
    import hier_dispatch_pkg::*;
#(
    parameter int N = NUM_CHILDREN_DEF,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] last_grant_i,
    input  logic [N-1:0]     nonzero_i,
    output logic [N-1:0]     grant_o,
    output logic             found_o
);

    logic [IDX_W:0]   shift;
    logic [2*N-1:0]   dbl_req;
    logic [2*N-1:0]   dbl_gnt;
    logic [N-1:0]     rot_req;
    logic [N-1:0]     first_oh;
    logic             hit;

    // Rotate so that bit 0 is the child right after last_grant, pick lowest, rotate back.
    assign shift   = {1'b0, last_grant_i} + (IDX_W+1)'(1);
    assign dbl_req = {nonzero_i, nonzero_i} >> shift;
    assign rot_req = dbl_req[N-1:0];

    always_comb begin
        first_oh = '0;
        hit      = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!hit && rot_req[j]) begin
                first_oh[j] = 1'b1;
                hit         = 1'b1;
            end
        end
    end

    assign dbl_gnt = {{N{1'b0}}, first_oh} << shift;
    assign grant_o = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
    assign found_o = |rot_req;

endmodule

// File: rtl/hier_fanout_dispatcher.sv
// Accepts one word from the parent and hands it to one credit-holding child, round-robin.
//   state  | meaning
//   IDLE   | ready for a parent word, nothing held
//   SELECT | word held, searching for a child with credit
//   SEND   | out_valid raised on the chosen lane, waiting for its out_ready
module hier_fanout_dispatcher
    import hier_dispatch_pkg::*;
#(
    parameter int NUM_CHILDREN = NUM_CHILDREN_DEF,
    parameter int DATA_W       = 32,
    parameter int CREDITS      = CREDITS_DEF,
    parameter int CNT_W        = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_W-1:0]       in_data_i,
    output logic [NUM_CHILDREN-1:0] out_valid_o,
    input  logic [NUM_CHILDREN-1:0] out_ready_i,
    output logic [DATA_W-1:0]       out_data_o,
    input  logic [NUM_CHILDREN-1:0] credit_return_i,
    output logic                    idle_o,
    output logic [CNT_W-1:0]        dispatch_cnt_o,
    output logic                    credit_err_o
);

    localparam int      IDX_W    = $clog2(NUM_CHILDREN);
    localparam credit_t CRED_MAX = credit_t'(CREDITS);

    state_e                  state_q;
    logic                    in_ready_q;
    logic                    idle_q;
    logic [NUM_CHILDREN-1:0] out_valid_q;
    logic [DATA_W-1:0]       hold_q;
    logic [IDX_W-1:0]        last_grant_q;
    logic [IDX_W-1:0]        sel_q;
    logic [CNT_W-1:0]        cnt_q;
    credit_t                 credit_q [NUM_CHILDREN];
    credit_t                 credit_d [NUM_CHILDREN];
    logic                    err_q;
    logic                    err_d;

    logic [NUM_CHILDREN-1:0] nonzero;
    logic [NUM_CHILDREN-1:0] grant;
    logic                    found;
    logic [IDX_W-1:0]        grant_idx;
    logic                    transfer;
    logic [NUM_CHILDREN-1:0] dispatch_vec;

    always_comb begin
        nonzero = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            nonzero[i] = (credit_q[i] != '0);
        end
    end

    rr_credit_arbiter #(.N(NUM_CHILDREN)) u_arb (
        .last_grant_i (last_grant_q),
        .nonzero_i    (nonzero),
        .grant_o      (grant),
        .found_o      (found)
    );

    always_comb begin
        grant_idx = '0;
        for (int j = 0; j < NUM_CHILDREN; j++) begin
            if (grant[j]) grant_idx = IDX_W'(j);
        end
    end

    assign transfer     = (state_q == SEND) && |(out_valid_q & out_ready_i);
    assign dispatch_vec = transfer ? out_valid_q : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            idle_q       <= 1'b1;
            out_valid_q  <= '0;
            hold_q       <= '0;
            last_grant_q <= IDX_W'(NUM_CHILDREN - 1);
            sel_q        <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid_i && in_ready_q) begin
                        hold_q     <= in_data_i;
                        in_ready_q <= 1'b0;
                        idle_q     <= 1'b0;
                        state_q    <= SELECT;
                    end
                end
                SELECT: begin
                    if (found) begin
                        sel_q       <= grant_idx;
                        out_valid_q <= grant;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (transfer) begin
                        last_grant_q <= sel_q;
                        cnt_q        <= cnt_q + CNT_W'(1);
                        out_valid_q  <= '0;
                        in_ready_q   <= 1'b1;
                        idle_q       <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= '0;
                    in_ready_q  <= 1'b0;
                    idle_q      <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Return and dispatch on the same lane cancel; a return into a full counter is an error.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            credit_d[i] = credit_q[i];
            if (credit_return_i[i] && !dispatch_vec[i]) begin
                if (credit_q[i] == CRED_MAX) err_d = 1'b1;
                else                         credit_d[i] = credit_q[i] + credit_t'(1);
            end else if (dispatch_vec[i] && !credit_return_i[i]) begin
                credit_d[i] = credit_q[i] - credit_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CHILDREN; i++) credit_q[i] <= CRED_MAX;
            err_q <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign in_ready_o     = in_ready_q;
    assign idle_o         = idle_q;
    assign out_valid_o    = out_valid_q;
    assign out_data_o     = hold_q;
    assign dispatch_cnt_o = cnt_q;
    assign credit_err_o   = err_q;

endmodule
